// File: rtl/mem_access_ctrl_pkg.sv
// Shared types for the MEM-stage data bus controller: access kinds, bus size
// codes and the byte-lane helpers used when a request is captured.
package mem_access_ctrl_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [3:0] {
    MEM_NONE,
    MEM_LB,
    MEM_LBU,
    MEM_LH,
    MEM_LHU,
    MEM_LW,
    MEM_SB,
    MEM_SH,
    MEM_SW
  } mem_t;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  function automatic logic is_misaligned(input mem_t kind, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (kind)
      MEM_LH, MEM_LHU, MEM_SH: bad = lo[0];
      MEM_LW, MEM_SW:          bad = (lo != 2'b00);
      default:                 bad = 1'b0;
    endcase
    return bad;
  endfunction

  function automatic logic [1:0] size_of(input mem_t kind);
    logic [1:0] sz;
    sz = SIZE_WORD;
    case (kind)
      MEM_LB, MEM_LBU, MEM_SB: sz = SIZE_BYTE;
      MEM_LH, MEM_LHU, MEM_SH: sz = SIZE_HALF;
      default:                 sz = SIZE_WORD;
    endcase
    return sz;
  endfunction

  // Loads drive no strobes, so the bus can tell reads from writes by strobe alone.
  function automatic logic [3:0] strobe_of(input mem_t kind, input logic [1:0] lo);
    logic [3:0] strb;
    strb = '0;
    case (kind)
      MEM_SB:  strb = 4'b0001 << lo;
      MEM_SH:  strb = 4'b0011 << {lo[1], 1'b0};
      MEM_SW:  strb = 4'b1111;
      default: strb = '0;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// Picks the addressed byte/half out of a raw bus word and sign- or
// zero-extends it according to the load kind.
module load_extend
  import mem_access_ctrl_pkg::*;
(
  input  logic [1:0] addr_lo,
  input  mem_t       kind,
  input  word_t      raw,
  output word_t      ext
);

  word_t shifted;

  always_comb begin
    shifted = raw >> {addr_lo, 3'b000};
    ext     = '0;
    case (kind)
      MEM_LB:  ext = {{24{shifted[7]}}, shifted[7:0]};
      MEM_LBU: ext = {24'h000000, shifted[7:0]};
      MEM_LH:  ext = {{16{shifted[15]}}, shifted[15:0]};
      MEM_LHU: ext = {16'h0000, shifted[15:0]};
      MEM_LW:  ext = shifted;
      default: ext = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// MEM-stage controller: issues one load/store at a time on the valid/addr_ok/
// data_ok data bus, stalls the pipeline until it completes and extends loads.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  input  mem_t              req_type,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              flush,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              addr_err,
  output logic              dbus_valid,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [3:0]        dbus_strobe,
  output logic [DATA_W-1:0] dbus_wdata,
  output logic [1:0]        dbus_size,
  input  logic              dbus_addr_ok,
  input  logic              dbus_data_ok,
  input  logic [DATA_W-1:0] dbus_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t     state_q, state_d;
  logic       drop_q, drop_d;
  logic       latch_rdata;
  logic       accept;
  logic       capture;
  mem_t       type_q;
  logic [1:0] lo_q;
  word_t      ext_word;

  assign addr_err = is_misaligned(req_type, req_addr[1:0]);
  assign accept   = req_valid && (req_type != MEM_NONE) && !addr_err && !flush;
  assign capture  = (state_q == ST_IDLE) && accept;

  assign dbus_valid = (state_q == ST_REQ);
  assign done       = (state_q == ST_DONE);
  assign stall      = accept && !done;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  // A flush after addr_ok cannot cancel the bus transaction, so it is remembered
  // in drop_q and the response is swallowed instead of producing done.
  always_comb begin
    state_d     = state_q;
    drop_d      = drop_q;
    latch_rdata = 1'b0;
    case (state_q)
      ST_IDLE: begin
        drop_d = 1'b0;
        if (accept) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (dbus_addr_ok) begin
          if (dbus_data_ok) begin
            state_d     = flush ? ST_IDLE : ST_DONE;
            latch_rdata = !flush;
          end else begin
            state_d = ST_WAIT;
            drop_d  = flush;
          end
        end else if (flush) begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (flush) drop_d = 1'b1;
        if (dbus_data_ok) begin
          drop_d = 1'b0;
          if (drop_q || flush) begin
            state_d = ST_IDLE;
          end else begin
            state_d     = ST_DONE;
            latch_rdata = 1'b1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
    endcase
  end

  load_extend u_load_extend (
    .addr_lo (lo_q),
    .kind    (type_q),
    .raw     (dbus_rdata),
    .ext     (ext_word)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      type_q      <= MEM_NONE;
      lo_q        <= '0;
      dbus_addr   <= '0;
      dbus_strobe <= '0;
      dbus_wdata  <= '0;
      dbus_size   <= '0;
      rdata       <= '0;
    end else begin
      if (capture) begin
        type_q      <= req_type;
        lo_q        <= req_addr[1:0];
        dbus_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
        dbus_strobe <= strobe_of(req_type, req_addr[1:0]);
        dbus_wdata  <= req_wdata << {req_addr[1:0], 3'b000};
        dbus_size   <= size_of(req_type);
      end
      if (latch_rdata) rdata <= ext_word;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: inputs change on the falling edge and
// outputs are sampled 1ns later, well away from the rising edge.
module tb_mem_access_ctrl;
  import mem_access_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        req_valid;
  mem_t        req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] rdata;
  logic        addr_err;
  logic        dbus_valid;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_strobe;
  logic [31:0] dbus_wdata;
  logic [1:0]  dbus_size;
  logic        dbus_addr_ok;
  logic        dbus_data_ok;
  logic [31:0] dbus_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_type     (req_type),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .flush        (flush),
    .stall        (stall),
    .done         (done),
    .rdata        (rdata),
    .addr_err     (addr_err),
    .dbus_valid   (dbus_valid),
    .dbus_addr    (dbus_addr),
    .dbus_strobe  (dbus_strobe),
    .dbus_wdata   (dbus_wdata),
    .dbus_size    (dbus_size),
    .dbus_addr_ok (dbus_addr_ok),
    .dbus_data_ok (dbus_data_ok),
    .dbus_rdata   (dbus_rdata)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic drive_req(input mem_t t, input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1; req_type = t; req_addr = a; req_wdata = wd;
  endtask

  task automatic idle_inputs();
    req_valid = 1'b0; req_type = MEM_NONE; req_addr = '0; req_wdata = '0; flush = 1'b0;
    dbus_addr_ok = 1'b0; dbus_data_ok = 1'b0; dbus_rdata = '0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; idle_inputs();
    tick(); tick(); #1;
    n_cmp++; if (dbus_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b want 0", dbus_valid); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (dbus_strobe !== 4'h0) begin n_bad++; $display("FAIL rst_strobe: got %h want 0", dbus_strobe); end
    n_cmp++; if (dbus_addr !== 32'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", dbus_addr); end
    n_cmp++; if (dbus_wdata !== 32'h0) begin n_bad++; $display("FAIL rst_wdata: got %h want 0", dbus_wdata); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL rst_stall: got %b want 0", stall); end
    tick(); resetn = 1'b1;
  endtask

  task automatic test_store_word();
    tick(); drive_req(MEM_SW, 32'h100, 32'hDEADBEEF); #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL sw_stall_c0: got %b want 1", stall); end
    n_cmp++; if (dbus_valid !== 1'b0) begin n_bad++; $display("FAIL sw_valid_c0: got %b want 0", dbus_valid); end
    tick(); #1;
    n_cmp++; if (dbus_valid !== 1'b1) begin n_bad++; $display("FAIL sw_valid_c1: got %b want 1", dbus_valid); end
    n_cmp++; if (dbus_addr !== 32'h100) begin n_bad++; $display("FAIL sw_addr: got %h want 00000100", dbus_addr); end
    n_cmp++; if (dbus_strobe !== 4'hF) begin n_bad++; $display("FAIL sw_strobe: got %h want f", dbus_strobe); end
    n_cmp++; if (dbus_wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_wdata: got %h want deadbeef", dbus_wdata); end
    n_cmp++; if (dbus_size !== 2'd2) begin n_bad++; $display("FAIL sw_size: got %0d want 2", dbus_size); end
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL sw_stall_c1: got %b want 1", stall); end
    tick(); dbus_addr_ok = 1'b1; #1;
    n_cmp++; if (dbus_valid !== 1'b1) begin n_bad++; $display("FAIL sw_valid_c2: got %b want 1", dbus_valid); end
    tick(); dbus_addr_ok = 1'b0; #1;
    n_cmp++; if (dbus_valid !== 1'b0) begin n_bad++; $display("FAIL sw_valid_c3: got %b want 0", dbus_valid); end
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL sw_stall_c3: got %b want 1", stall); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL sw_done_c3: got %b want 0", done); end
    tick(); dbus_data_ok = 1'b1; #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL sw_stall_c4: got %b want 1", stall); end
    tick(); dbus_data_ok = 1'b0; #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL sw_done_c5: got %b want 1", done); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL sw_stall_c5: got %b want 0", stall); end
    tick(); idle_inputs(); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL sw_done_c6: got %b want 0", done); end
  endtask

  task automatic test_store_byte();
    tick(); drive_req(MEM_SB, 32'h103, 32'h000000AB); #1;
    tick(); #1;
    n_cmp++; if (dbus_strobe !== 4'b1000) begin n_bad++; $display("FAIL sb_strobe: got %b want 1000", dbus_strobe); end
    n_cmp++; if (dbus_wdata !== 32'hAB000000) begin n_bad++; $display("FAIL sb_wdata: got %h want ab000000", dbus_wdata); end
    n_cmp++; if (dbus_size !== 2'd0) begin n_bad++; $display("FAIL sb_size: got %0d want 0", dbus_size); end
    n_cmp++; if (dbus_addr !== 32'h100) begin n_bad++; $display("FAIL sb_addr: got %h want 00000100", dbus_addr); end
    dbus_addr_ok = 1'b1; dbus_data_ok = 1'b1;
    tick(); dbus_addr_ok = 1'b0; dbus_data_ok = 1'b0; #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL sb_done: got %b want 1", done); end
    n_cmp++; if (dbus_valid !== 1'b0) begin n_bad++; $display("FAIL sb_valid_done: got %b want 0", dbus_valid); end
    tick(); idle_inputs(); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL sb_done_width: got %b want 0", done); end
  endtask

  task automatic run_load(input mem_t t, input logic [31:0] a, input logic [31:0] raw,
                          input logic [31:0] exp, input string nm);
    tick(); drive_req(t, a, 32'h0); #1;
    tick(); #1;
    n_cmp++; if (dbus_strobe !== 4'h0) begin n_bad++; $display("FAIL %s_strobe: got %h want 0", nm, dbus_strobe); end
    n_cmp++; if (dbus_addr !== {a[31:2], 2'b00}) begin n_bad++; $display("FAIL %s_addr: got %h want %h", nm, dbus_addr, {a[31:2], 2'b00}); end
    dbus_addr_ok = 1'b1; dbus_data_ok = 1'b1; dbus_rdata = raw;
    tick(); dbus_addr_ok = 1'b0; dbus_data_ok = 1'b0; dbus_rdata = 32'h0; #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL %s_done: got %b want 1", nm, done); end
    n_cmp++; if (rdata !== exp) begin n_bad++; $display("FAIL %s_rdata: got %h want %h", nm, rdata, exp); end
    tick(); idle_inputs();
  endtask

  task automatic test_loads();
    run_load(MEM_LB,  32'h102, 32'h12803456, 32'hFFFFFF80, "lb");
    run_load(MEM_LBU, 32'h102, 32'h12803456, 32'h00000080, "lbu");
    run_load(MEM_LB,  32'h101, 32'h12803456, 32'h00000034, "lb_pos");
    run_load(MEM_LH,  32'h100, 32'h8000F00D, 32'hFFFFF00D, "lh");
    run_load(MEM_LHU, 32'h102, 32'h8000F00D, 32'h00008000, "lhu");
    run_load(MEM_LW,  32'h104, 32'hCAFEF00D, 32'hCAFEF00D, "lw");
  endtask

  task automatic test_load_wait();
    tick(); drive_req(MEM_LB, 32'h103, 32'h0); #1;
    tick(); dbus_addr_ok = 1'b1; #1;
    n_cmp++; if (dbus_size !== 2'd0) begin n_bad++; $display("FAIL lbw_size: got %0d want 0", dbus_size); end
    tick(); dbus_addr_ok = 1'b0; dbus_data_ok = 1'b1; dbus_rdata = 32'h9A000000; #1;
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lbw_stall: got %b want 1", stall); end
    tick(); dbus_data_ok = 1'b0; dbus_rdata = 32'h0; #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL lbw_done: got %b want 1", done); end
    n_cmp++; if (rdata !== 32'hFFFFFF9A) begin n_bad++; $display("FAIL lbw_rdata: got %h want ffffff9a", rdata); end
    tick(); idle_inputs();
  endtask

  task automatic test_misaligned();
    tick(); drive_req(MEM_LH, 32'h101, 32'h0); #1;
    n_cmp++; if (addr_err !== 1'b1) begin n_bad++; $display("FAIL mis_lh_err: got %b want 1", addr_err); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL mis_lh_stall: got %b want 0", stall); end
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      n_cmp++; if (dbus_valid !== 1'b0 || done !== 1'b0) begin n_bad++; $display("FAIL mis_lh_bus: got valid=%b done=%b want 0/0", dbus_valid, done); end
    end
    req_type = MEM_SW; req_addr = 32'h102; #1;
    n_cmp++; if (addr_err !== 1'b1) begin n_bad++; $display("FAIL mis_sw_err: got %b want 1", addr_err); end
    req_valid = 1'b0; req_type = MEM_LHU; req_addr = 32'h102; #1;
    n_cmp++; if (addr_err !== 1'b0) begin n_bad++; $display("FAIL ok_lhu_err: got %b want 0", addr_err); end
    req_type = MEM_LB; req_addr = 32'h103; #1;
    n_cmp++; if (addr_err !== 1'b0) begin n_bad++; $display("FAIL ok_lb_err: got %b want 0", addr_err); end
    idle_inputs();
  endtask

  task automatic test_flush_wait();
    tick(); drive_req(MEM_LW, 32'h300, 32'h0); #1;
    tick(); dbus_addr_ok = 1'b1; #1;
    tick(); dbus_addr_ok = 1'b0; flush = 1'b1; #1;
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fw_stall: got %b want 0", stall); end
    n_cmp++; if (dbus_valid !== 1'b0) begin n_bad++; $display("FAIL fw_valid: got %b want 0", dbus_valid); end
    tick(); flush = 1'b0; req_valid = 1'b0; req_type = MEM_NONE;
    tick();
    tick(); dbus_data_ok = 1'b1; dbus_rdata = 32'h11111111; #1;
    tick(); dbus_data_ok = 1'b0; dbus_rdata = 32'h0; drive_req(MEM_SH, 32'h202, 32'h00001234); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL fw_no_done: got %b want 0", done); end
    tick(); #1;
    n_cmp++; if (dbus_valid !== 1'b1) begin n_bad++; $display("FAIL fw_sh_valid: got %b want 1", dbus_valid); end
    n_cmp++; if (dbus_strobe !== 4'b1100) begin n_bad++; $display("FAIL fw_sh_strobe: got %b want 1100", dbus_strobe); end
    n_cmp++; if (dbus_wdata !== 32'h12340000) begin n_bad++; $display("FAIL fw_sh_wdata: got %h want 12340000", dbus_wdata); end
    n_cmp++; if (dbus_size !== 2'd1) begin n_bad++; $display("FAIL fw_sh_size: got %0d want 1", dbus_size); end
    dbus_addr_ok = 1'b1; dbus_data_ok = 1'b1;
    tick(); dbus_addr_ok = 1'b0; dbus_data_ok = 1'b0; #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL fw_sh_done: got %b want 1", done); end
    tick(); idle_inputs();
  endtask

  task automatic test_flush_req();
    tick(); drive_req(MEM_SW, 32'h500, 32'h0); #1;
    tick(); flush = 1'b1; req_valid = 1'b0; #1;
    tick(); flush = 1'b0; #1;
    n_cmp++; if (dbus_valid !== 1'b0) begin n_bad++; $display("FAIL fr_valid: got %b want 0", dbus_valid); end
    tick(); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL fr_done: got %b want 0", done); end
    // flush and data_ok together in WAIT
    tick(); drive_req(MEM_LW, 32'h600, 32'h0); #1;
    tick(); dbus_addr_ok = 1'b1; #1;
    tick(); dbus_addr_ok = 1'b0; flush = 1'b1; dbus_data_ok = 1'b1; dbus_rdata = 32'h77777777; #1;
    tick(); idle_inputs(); #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL fwd_done: got %b want 0", done); end
    n_cmp++; if (rdata === 32'h77777777) begin n_bad++; $display("FAIL fwd_rdata: got %h want not 77777777", rdata); end
  endtask

  task automatic test_reset_mid();
    tick(); drive_req(MEM_SW, 32'h400, 32'h00000055); #1;
    tick(); #1;
    n_cmp++; if (dbus_valid !== 1'b1) begin n_bad++; $display("FAIL rm_valid_pre: got %b want 1", dbus_valid); end
    resetn = 1'b0; req_valid = 1'b0; req_type = MEM_NONE;
    tick(); #1;
    n_cmp++; if (dbus_valid !== 1'b0) begin n_bad++; $display("FAIL rm_valid: got %b want 0", dbus_valid); end
    n_cmp++; if (dbus_strobe !== 4'h0 || dbus_addr !== 32'h0 || dbus_wdata !== 32'h0) begin
      n_bad++; $display("FAIL rm_regs: got strobe=%h addr=%h wdata=%h want 0/0/0", dbus_strobe, dbus_addr, dbus_wdata);
    end
    resetn = 1'b1; dbus_data_ok = 1'b1;
    tick(); dbus_data_ok = 1'b0; #1;
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rm_done1: got %b want 0", done); end
    tick(); #1;
    n_cmp++; if (done !== 1'b0 || dbus_valid !== 1'b0) begin n_bad++; $display("FAIL rm_idle: got done=%b valid=%b want 0/0", done, dbus_valid); end
  endtask

  task automatic test_back_to_back();
    tick(); drive_req(MEM_SB, 32'h000, 32'h11); #1;
    tick(); dbus_addr_ok = 1'b1; dbus_data_ok = 1'b1; #1;
    tick(); dbus_addr_ok = 1'b0; dbus_data_ok = 1'b0; drive_req(MEM_SB, 32'h001, 32'h22); #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done1: got %b want 1", done); end
    n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL b2b_stall_done: got %b want 0", stall); end
    tick(); #1;
    n_cmp++; if (dbus_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_gap_valid: got %b want 0", dbus_valid); end
    n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL b2b_gap_stall: got %b want 1", stall); end
    tick(); #1;
    n_cmp++; if (dbus_valid !== 1'b1) begin n_bad++; $display("FAIL b2b_valid2: got %b want 1", dbus_valid); end
    n_cmp++; if (dbus_strobe !== 4'b0010) begin n_bad++; $display("FAIL b2b_strobe2: got %b want 0010", dbus_strobe); end
    n_cmp++; if (dbus_wdata !== 32'h00002200) begin n_bad++; $display("FAIL b2b_wdata2: got %h want 00002200", dbus_wdata); end
    dbus_addr_ok = 1'b1; dbus_data_ok = 1'b1;
    tick(); dbus_addr_ok = 1'b0; dbus_data_ok = 1'b0; #1;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL b2b_done2: got %b want 1", done); end
    tick(); idle_inputs();
  endtask

  initial begin
    test_reset();
    test_store_word();
    test_store_byte();
    test_loads();
    test_load_wait();
    test_misaligned();
    test_flush_wait();
    test_flush_req();
    test_reset_mid();
    test_back_to_back();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
